// File: rtl/count_display_pkg.sv
// Shared types and constants for the egg-timer display back-end:
// converter states, iteration count and seven-segment patterns.
package count_display_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } conv_state_t;

  localparam logic [3:0] NUM_ITER = 4'd12;

  // Active-low patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: 12-bit binary to four BCD digits in
// 12 cycles, with a single merged pending request for strobes during CONV.
module bin2bcd_seq
  import count_display_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [11:0] i_bin,
  output logic        o_busy,
  output logic        o_valid,
  output logic [15:0] o_bcd
);

  conv_state_t r_state;
  logic        r_pending;
  logic [3:0]  r_iter;
  logic [27:0] r_shift;
  logic        r_valid;
  logic [15:0] r_bcd;
  logic [27:0] w_adj;
  logic [27:0] w_next;

  // Add-3 correction on every BCD nibble before the shift
  always_comb begin
    w_adj = r_shift;
    for (int k = 0; k < 4; k++) begin
      if (r_shift[12 + 4*k +: 4] >= 4'd5) begin
        w_adj[12 + 4*k +: 4] = r_shift[12 + 4*k +: 4] + 4'd3;
      end
    end
  end

  assign w_next = w_adj << 1;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
      r_iter    <= 4'd0;
      r_shift   <= 28'd0;
      r_valid   <= 1'b0;
      r_bcd     <= 16'h0000;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start || r_pending) begin
            r_shift   <= {16'h0000, i_bin};
            r_pending <= 1'b0;
            r_iter    <= 4'd0;
            r_state   <= CONV;
          end
        end
        CONV: begin
          r_shift <= w_next;
          r_iter  <= r_iter + 4'd1;
          if (i_start) begin
            r_pending <= 1'b1;
          end
          if (r_iter == NUM_ITER - 4'd1) begin
            r_bcd   <= w_next[27:12];
            r_valid <= 1'b1;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy  = (r_state == CONV);
  assign o_valid = r_valid;
  assign o_bcd   = r_bcd;

endmodule

// File: rtl/count_display.sv
// Egg-timer display back-end: BCD conversion plus multiplexed common-anode
// 4-digit scan. Define COUNT_DISPLAY_LZB_EN for leading-zero blanking.
module count_display
  import count_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] count_in,
  input  logic        update,
  input  logic        blank,
  output logic        busy,
  output logic        bcd_valid,
  output logic [15:0] bcd_out,
  output logic [3:0]  an_n,
  output logic [6:0]  seg_n
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic [15:0]   w_bcd;
  logic [3:0]    w_digit;
  logic          w_lzb;

  bin2bcd_seq u_conv (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_start (update),
    .i_bin   (count_in),
    .o_busy  (busy),
    .o_valid (bcd_valid),
    .o_bcd   (w_bcd)
  );

  always_comb begin
    case (r_idx)
      2'd0:    w_digit = w_bcd[3:0];
      2'd1:    w_digit = w_bcd[7:4];
      2'd2:    w_digit = w_bcd[11:8];
      default: w_digit = w_bcd[15:12];
    endcase
  end

`ifdef COUNT_DISPLAY_LZB_EN
  // A digit is dark when it and every higher digit are zero; ones always lit
  always_comb begin
    case (r_idx)
      2'd3:    w_lzb = (w_bcd[15:12] == 4'd0);
      2'd2:    w_lzb = (w_bcd[15:8] == 8'd0);
      2'd1:    w_lzb = (w_bcd[15:4] == 12'd0);
      default: w_lzb = 1'b0;
    endcase
  end
`else
  assign w_lzb = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
      r_an    <= 4'hF;
      r_seg   <= SEG_BLANK;
    end else begin
      if (r_presc == PRESC_MAX) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      r_an  <= blank ? 4'hF : ~(4'b0001 << r_idx);
      r_seg <= w_lzb ? SEG_BLANK : seg_decode(w_digit);
    end
  end

  assign bcd_out = w_bcd;
  assign an_n    = r_an;
  assign seg_n   = r_seg;

endmodule

// File: tb/tb_count_display.sv
// Directed self-checking bench for count_display with SCAN_DIV=4.
// Expectations follow COUNT_DISPLAY_LZB_EN when it is defined.
module tb_count_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] count_in = 12'd0;
  logic        update = 1'b0;
  logic        blank = 1'b0;
  logic        busy;
  logic        bcd_valid;
  logic [15:0] bcd_out;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          edgeCount = 0;
  logic [15:0] expBcd = 16'h0000;
  logic [6:0]  segTable [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  count_display #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .update    (update),
    .blank     (blank),
    .busy      (busy),
    .bcd_valid (bcd_valid),
    .bcd_out   (bcd_out),
    .an_n      (an_n),
    .seg_n     (seg_n)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock edge and settle; edgeCount tracks edges since reset release
  task automatic tick();
    @(posedge clk);
    if (!rst) edgeCount = 0;
    else edgeCount++;
    #1;
  endtask

  task automatic applyStimulus(input logic [11:0] value);
    count_in = value;
    update   = 1'b1;
    tick();
    update   = 1'b0;
  endtask

  function automatic logic [6:0] expSeg(input logic [15:0] b, input int idx);
    logic [3:0] d;
    logic       dark;
    d    = b[4*idx +: 4];
    dark = 1'b0;
`ifdef COUNT_DISPLAY_LZB_EN
    if (idx > 0 && (b >> (4*idx)) == 16'h0) dark = 1'b1;
`endif
    return dark ? 7'h7F : segTable[d];
  endfunction

  task automatic checkScan(input string tag);
    int         idx;
    logic [3:0] expAn;
    idx   = ((edgeCount - 1) / 4) % 4;
    expAn = blank ? 4'hF : ~(4'b0001 << idx);
    checkOutput({tag, "_an"}, {28'h0, an_n}, {28'h0, expAn});
    checkOutput({tag, "_seg"}, {25'h0, seg_n}, {25'h0, expSeg(expBcd, idx)});
  endtask

  // Pulse update with a value and wait (bounded) for the result pulse
  task automatic convertAndCheck(input string tag, input logic [11:0] value, input logic [15:0] exp);
    int seen;
    seen = 0;
    applyStimulus(value);
    for (int i = 0; i < 20 && seen == 0; i++) begin
      tick();
      if (bcd_valid) begin
        seen = 1;
        checkOutput({tag, "_bcd"}, {16'h0, bcd_out}, {16'h0, exp});
        checkOutput({tag, "_lat"}, i + 1, 12);
      end
    end
    checkOutput({tag, "_done"}, seen, 1);
  endtask

  initial begin
    int busyCount, validCount, pulses;
    int pulseAt [0:1];
    logic [15:0] pulseBcd [0:1];

    // Reset state
    repeat (3) tick();
    checkOutput("rst_busy", {31'h0, busy}, 0);
    checkOutput("rst_valid", {31'h0, bcd_valid}, 0);
    checkOutput("rst_bcd", {16'h0, bcd_out}, 0);
    checkOutput("rst_an", {28'h0, an_n}, 32'hF);
    checkOutput("rst_seg", {25'h0, seg_n}, 32'h7F);

    // Idle scan after release with bcd_out = 0
    rst = 1'b1;
    expBcd = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      tick();
      checkScan("scan0");
    end

    // Max value conversion and latency
    applyStimulus(12'd4095);
    checkOutput("c4095_busyN", {31'h0, busy}, 1);
    busyCount = 0;
    validCount = 0;
    for (int i = 1; i <= 11; i++) begin
      tick();
      busyCount += busy;
      validCount += bcd_valid;
    end
    checkOutput("c4095_busyCnt", busyCount, 11);
    checkOutput("c4095_earlyValid", validCount, 0);
    tick();
    checkOutput("c4095_busyEnd", {31'h0, busy}, 0);
    checkOutput("c4095_valid", {31'h0, bcd_valid}, 1);
    checkOutput("c4095_bcd", {16'h0, bcd_out}, 32'h4095);
    tick();
    checkOutput("c4095_pulse", {31'h0, bcd_valid}, 0);

    // Pending merge: two strobes during a conversion yield one follow-up
    applyStimulus(12'd300);
    pulses = 0;
    pulseAt[0] = 0;
    pulseAt[1] = 0;
    pulseBcd[0] = 16'h0;
    pulseBcd[1] = 16'h0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bcd_valid) begin
        if (pulses < 2) begin
          pulseAt[pulses] = i;
          pulseBcd[pulses] = bcd_out;
        end
        pulses++;
      end
      if (i == 3 || i == 7) begin
        count_in = 12'd7;
        update = 1'b1;
      end else begin
        update = 1'b0;
      end
    end
    checkOutput("pend_pulses", pulses, 2);
    checkOutput("pend_at0", pulseAt[0], 12);
    checkOutput("pend_bcd0", {16'h0, pulseBcd[0]}, 32'h0300);
    checkOutput("pend_at1", pulseAt[1], 25);
    checkOutput("pend_bcd1", {16'h0, pulseBcd[1]}, 32'h0007);

    // Blank gates anodes only; scan phase keeps advancing
    expBcd = 16'h0007;
    blank = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkScan("blank");
    end
    blank = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checkScan("unblank");
    end

    // Reset at iteration 6 abandons the conversion
    applyStimulus(12'd1234);
    repeat (5) tick();
    rst = 1'b0;
    tick();
    checkOutput("rstmid_busy", {31'h0, busy}, 0);
    checkOutput("rstmid_bcd", {16'h0, bcd_out}, 0);
    checkOutput("rstmid_valid", {31'h0, bcd_valid}, 0);
    rst = 1'b1;
    validCount = 0;
    busyCount = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      validCount += bcd_valid;
      busyCount += busy;
    end
    checkOutput("rstmid_noValid", validCount, 0);
    checkOutput("rstmid_noBusy", busyCount, 0);
    convertAndCheck("c1234", 12'd1234, 16'h1234);

    // Small value: leading-zero handling of the upper digits
    convertAndCheck("c5", 12'd5, 16'h0005);
    tick();
    expBcd = 16'h0005;
    for (int i = 0; i < 16; i++) begin
      tick();
      checkScan("scan5");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
